f_imem_responder: RTL and testbench

Instruction-memory responder at the far end of the fetch interface. Accepts fetch requests carrying a byte address from the F-stage program counter and returns the addressed instruction word after a fixed latency. Responses are buffered in order behind a valid/ready handshake so that a D-stage stall never drops a word. A flush input discards stale fetches on redirect, and a backdoor write port preloads the program.

---
 rtl/f_imem_responder_if.sv | 47 ++++
 rtl/f_imem_responder.sv | 184 ++++++++++++++++++
 tb/tb_f_imem_responder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/f_imem_responder_if.sv
// ---------------------------------------------------------------------------
// f_imem_responder_if
//
// Fetch-side bus between the F-stage (master) and the instruction-memory
// responder (slave).
//
//   req_valid   master -> slave   fetch request present
//   req_ready   slave  -> master  responder can take a request this cycle
//   req_addr    master -> slave   fetch byte address (PC)
//   resp_valid  slave  -> master  response at head of the response buffer
//   resp_ready  master -> slave   consumer takes the response (low = stall)
//   resp_instr  slave  -> master  instruction word (zero on error)
//   resp_pc     slave  -> master  request address echoed back
//   resp_err    slave  -> master  request was misaligned or out of range
// ---------------------------------------------------------------------------
interface f_imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_pc;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_instr,
        input  resp_pc,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_instr,
        output resp_pc,
        output resp_err
    );
endinterface

// File: rtl/f_imem_responder.sv
// ---------------------------------------------------------------------------
// f_imem_responder
//
// Instruction-memory responder at the far end of the fetch interface.
// Fetch requests carrying a byte PC are checked for alignment/range, the
// addressed word is read and carried down a LATENCY-1 deep pipeline, and the
// result is pushed into an in-order response FIFO whose head drives the
// resp_* outputs. The number of outstanding requests (in the pipeline plus
// queued) never exceeds BUF_DEPTH, so the FIFO cannot overflow and a stalled
// consumer never loses a word. Flush and reset discard all outstanding work;
// the memory contents survive both.
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high
//   bus      fetch bus (slave side): request and response handshakes
//   flush    discard every in-flight and queued fetch at the next edge
//   ld_en    backdoor write enable
//   ld_idx   backdoor word index
//   ld_data  backdoor write data
// ---------------------------------------------------------------------------
module f_imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2,
    parameter int          BUF_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    f_imem_responder_if.slave              bus,
    input  logic                           flush,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx,
    input  logic [31:0]                    ld_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // LATENCY=1 needs no pipeline register; keep the array legal anyway.
    localparam int PIPE  = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    // End of the mapped window, one bit wider so it cannot wrap.
    localparam logic [32:0]      ADDR_END = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic  valid;
        resp_t data;
    } stage_t;

    // Program store. Written only through the backdoor port, never reset.
    logic [31:0]      mem_q [DEPTH_WORDS];

    stage_t           stage_q [PIPE];
    stage_t           stage_d [PIPE];
    resp_t            fifo_q  [BUF_DEPTH];
    resp_t            fifo_d  [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             addr_err;
    logic [IDX_W-1:0] rd_idx;
    logic             req_ready_w;
    logic             resp_valid_w;
    logic             accept;
    logic             pop;
    logic             clear;
    stage_t           new_entry;
    stage_t           push_entry;
    resp_t            head;

    // Address decode: misaligned or outside the window is an error; the word
    // index is the offset from BASE_ADDR in words, truncated to the index width.
    always_comb begin
        addr_err = (bus.req_addr[1:0] != 2'b00)
                || (bus.req_addr < BASE_ADDR)
                || ({1'b0, bus.req_addr} >= ADDR_END);
        rd_idx   = IDX_W'((bus.req_addr - BASE_ADDR) >> 2);
    end

    // Handshakes. The pop term in req_ready lets a new request in while the
    // buffer is at its limit, as long as a response leaves in the same cycle.
    always_comb begin
        resp_valid_w = (fifo_cnt_q != '0);
        pop          = resp_valid_w && bus.resp_ready;
        req_ready_w  = !flush && !reset && ((cnt_q < CNT_MAX) || pop);
        accept       = bus.req_valid && req_ready_w;
        clear        = reset || flush;
    end

    // Entry launched into the pipeline this cycle. The memory is read before
    // the edge, so a backdoor write to the same index lands after this read
    // and the fetch sees the old word.
    always_comb begin
        new_entry            = '0;
        new_entry.valid      = accept;
        new_entry.data.pc    = bus.req_addr;
        new_entry.data.err   = addr_err;
        new_entry.data.instr = addr_err ? 32'h0 : mem_q[rd_idx];
    end

    // Latency pipeline: stage 0 captures the new entry, the last stage feeds
    // the FIFO. With LATENCY=1 the new entry goes straight into the FIFO.
    always_comb begin
        stage_d[0] = new_entry;
        for (int i = 1; i < PIPE; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        push_entry = stage_q[PIPE-1];
        if (LATENCY == 1) begin
            push_entry = new_entry;
        end
        if (clear) begin
            for (int i = 0; i < PIPE; i++) begin
                stage_d[i].valid = 1'b0;
            end
        end
    end

    // Response FIFO and outstanding count. Pointers wrap modulo BUF_DEPTH;
    // fifo_cnt distinguishes full from empty. cnt covers pipeline plus FIFO.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push_entry.valid) - CNT_W'(pop);
        cnt_d      = cnt_q + CNT_W'(accept) - CNT_W'(pop);

        if (push_entry.valid) begin
            fifo_d[wr_ptr_q] = push_entry.data;
            wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        // A pop in the flush cycle is already consumed, so dropping
        // everything here loses nothing the consumer has not taken.
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            cnt_d      = '0;
        end
    end

    // Head of the FIFO drives the response; outputs read zero when empty.
    always_comb begin
        head = fifo_q[rd_ptr_q];
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.resp_valid = resp_valid_w;
    assign bus.resp_instr = resp_valid_w ? head.instr : 32'h0;
    assign bus.resp_pc    = resp_valid_w ? head.pc    : 32'h0;
    assign bus.resp_err   = resp_valid_w && head.err;

    always_ff @(posedge clk) begin
        stage_q    <= stage_d;
        fifo_q     <= fifo_d;
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        fifo_cnt_q <= fifo_cnt_d;
        cnt_q      <= cnt_d;
    end

    // Backdoor program load; independent of reset and flush.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

endmodule

// File: tb/tb_f_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_f_imem_responder
//
// Self-checking bench for f_imem_responder (LATENCY=2, BUF_DEPTH=4,
// BASE_ADDR=0x3000, DEPTH_WORDS=4096). Stimulus pushes the expected response
// for every accepted request into a scoreboard queue; a monitor on the
// falling edge pops and compares on each response handshake, and for timed
// requests also checks the cycle the response appears.
// ---------------------------------------------------------------------------
module tb_f_imem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    f_imem_responder_if bus ();

    f_imem_responder #(
        .BASE_ADDR   (32'h0000_3000),
        .DEPTH_WORDS (4096),
        .LATENCY     (LAT),
        .BUF_DEPTH   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .flush   (flush),
        .ld_en   (ld_en),
        .ld_idx  (ld_idx),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   cyc       = 0;
    int   resp_seen = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Program image used for preload: two fixed words, then a tagged pattern.
    function automatic logic [31:0] pat(input int k);
        if (k == 0) return 32'h3c01_1234;
        if (k == 1) return 32'h3421_0001;
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    // Scoreboard monitor: compare every response handshake against the queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.resp_valid && bus.resp_ready) begin
                resp_seen++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("[TB] FAIL resp_unexpected: got pc %0h, expected no response", bus.resp_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", {bus.resp_pc, bus.resp_instr, bus.resp_err},
                          {e.pc, e.instr, e.err});
                    if (e.due >= 0) check("resp_cycle", 128'(cyc), 128'(e.due));
                end
            end
            if (flush) exp_q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_idx  = 12'(idx);
        ld_data = data;
        step();
        ld_en   = 1'b0;
    endtask

    // Present one request for one cycle; if it is taken, queue its expectation.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] instr,
                                 input logic err, input bit timed, output bit acc);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        acc = bus.req_ready;
        if (acc) begin
            e.pc    = addr;
            e.instr = instr;
            e.err   = err;
            e.due   = timed ? cyc + LAT : -1;
            exp_q.push_back(e);
        end
        step();
        bus.req_valid = 1'b0;
    endtask

    // Wait a bounded time for every expected response, then check idle.
    task automatic checkOutput(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        check({name, "_drain"}, 128'(exp_q.size()), 128'(0));
        step();
        step();
        @(negedge clk);
        check({name, "_idle"}, 128'(bus.resp_valid), 128'(0));
        step();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit acc;
        int n_acc;
        int seen0;

        reset = 1'b1; flush = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        @(negedge clk);
        check("rst_valid", 128'(bus.resp_valid), 128'(0));
        check("rst_instr", 128'(bus.resp_instr), 128'(0));
        check("rst_pc",    128'(bus.resp_pc),    128'(0));
        check("rst_err",   128'(bus.resp_err),   128'(0));
        check("rst_ready", 128'(bus.req_ready),  128'(1));
        step();

        for (int k = 0; k < 100; k++) load(k, pat(k));
        load(4095, 32'hC0DE_0FFF);

        // Two consecutive fetches, responses LAT cycles after acceptance.
        bus.resp_ready = 1'b1;
        applyStimulus(32'h3000, 32'h3c01_1234, 1'b0, 1'b1, acc);
        applyStimulus(32'h3004, 32'h3421_0001, 1'b0, 1'b1, acc);
        checkOutput("t1");

        // Stall: six requests, only four fit.
        $display("[TB] stall test");
        bus.resp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'h3000 + 32'(4*i), pat(i), 1'b0, 1'b0, acc);
            check($sformatf("t2_ready%0d", i), 128'(acc), 128'(i < 4));
            n_acc += int'(acc);
        end
        check("t2_accepted", 128'(n_acc), 128'(4));
        seen0 = resp_seen;
        bus.resp_ready = 1'b1;
        checkOutput("t2");
        check("t2_delivered", 128'(resp_seen - seen0), 128'(4));

        // Address errors and the last valid word.
        applyStimulus(32'h3002, 32'h0, 1'b1, 1'b1, acc);
        applyStimulus(32'h2ffc, 32'h0, 1'b1, 1'b1, acc);
        applyStimulus(32'h7000, 32'h0, 1'b1, 1'b1, acc);
        applyStimulus(32'h6ffc, 32'hC0DE_0FFF, 1'b0, 1'b1, acc);
        checkOutput("t3");

        // Flush with three outstanding.
        $display("[TB] flush test");
        bus.resp_ready = 1'b0;
        applyStimulus(32'h3000, 32'h3c01_1234, 1'b0, 1'b0, acc);
        applyStimulus(32'h3004, 32'h3421_0001, 1'b0, 1'b0, acc);
        applyStimulus(32'h3008, 32'hC0DE_0002, 1'b0, 1'b0, acc);
        step();
        flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h300c;
        @(negedge clk);
        check("t4_ready_in_flush", 128'(bus.req_ready), 128'(0));
        step();
        flush = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("t4_valid_after_flush", 128'(bus.resp_valid), 128'(0));
        step();
        bus.resp_ready = 1'b1;
        applyStimulus(32'h3008, 32'hC0DE_0002, 1'b0, 1'b1, acc);
        checkOutput("t4");

        // Reset mid-stream with two outstanding.
        $display("[TB] reset test");
        bus.resp_ready = 1'b0;
        applyStimulus(32'h3000, 32'h3c01_1234, 1'b0, 1'b0, acc);
        applyStimulus(32'h3004, 32'h3421_0001, 1'b0, 1'b0, acc);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t5_valid", 128'(bus.resp_valid), 128'(0));
        check("t5_instr", 128'(bus.resp_instr), 128'(0));
        check("t5_pc",    128'(bus.resp_pc),    128'(0));
        check("t5_err",   128'(bus.resp_err),   128'(0));
        step();
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h3000 + 32'(4*i), pat(i), 1'b0, 1'b0, acc);
            n_acc += int'(acc);
        end
        check("t5_accepted_after_reset", 128'(n_acc), 128'(4));
        bus.resp_ready = 1'b1;
        checkOutput("t5");

        // Streaming: 100 sequential PCs, every response exactly LAT later.
        $display("[TB] streaming test");
        bus.resp_ready = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(32'h3000 + 32'(4*k), pat(k), 1'b0, 1'b1, acc);
            n_acc += int'(acc);
        end
        check("t6_accepted", 128'(n_acc), 128'(100));
        checkOutput("t6");

        // Same-cycle backdoor write and fetch of idx3: old word, then new.
        ld_en   = 1'b1;
        ld_idx  = 12'd3;
        ld_data = 32'h0BAD_F00D;
        applyStimulus(32'h300c, 32'hC0DE_0003, 1'b0, 1'b1, acc);
        ld_en   = 1'b0;
        applyStimulus(32'h300c, 32'h0BAD_F00D, 1'b0, 1'b1, acc);
        checkOutput("t7");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
